imem_arb: RTL

IMEM_ARB -- requirements
Module: imem_arb

---
 rtl/imem_arb.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/imem_arb.sv
// Single-port instruction memory arbiter: loader/debug port has priority over
// fetch, with a starvation bound that guarantees fetch forward progress.
module imem_arb #(
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned STARVE_MAX = 4,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    // fetch port
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    input  logic          f_flush,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    // loader / debug port
    input  logic          l_req,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          l_err,
    // instruction memory
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned SW  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_RESP = 2'd1,
        L_RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          resp_err;
    logic          resp_err_nxt;
    logic          wr_err;
    logic          wr_err_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic          starved;
    logic          f_ok;
    logic          l_ok;

    // Word-aligned and inside the memory window.
    assign f_ok = (f_addr[1:0] == 2'b00) && ((f_addr >> (AW + 2)) == 32'd0);
    assign l_ok = (l_addr[1:0] == 2'b00) && ((l_addr >> (AW + 2)) == 32'd0);

    assign starved = (starve_cnt == SW'(STARVE_MAX));

    // State register: response tracker, error latches, starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_err   <= 1'b0;
            wr_err     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            resp_err   <= resp_err_nxt;
            wr_err     <= wr_err_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Arbitration, memory command and next-state logic.
    always_comb begin
        f_gnt        = 1'b0;
        l_gnt        = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = l_wdata;
        state_nxt    = IDLE;
        resp_err_nxt = 1'b0;
        wr_err_nxt   = 1'b0;
        starve_nxt   = '0;

        if (rst_n) begin
            if (l_req && !(f_req && starved)) begin
                l_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end

        if (f_gnt) begin
            state_nxt    = F_RESP;
            resp_err_nxt = !f_ok;
            if (f_ok) begin
                mem_en   = 1'b1;
                mem_addr = f_addr[AW+1:2];
            end
        end else if (l_gnt) begin
            if (l_ok) begin
                mem_en   = 1'b1;
                mem_we   = l_we;
                mem_addr = l_addr[AW+1:2];
            end
            if (l_we) begin
                wr_err_nxt = !l_ok;
            end else begin
                state_nxt    = L_RESP;
                resp_err_nxt = !l_ok;
            end
        end

        // Saturating count of cycles fetch waited while requesting.
        if (f_req && !f_gnt) begin
            starve_nxt = starved ? starve_cnt : starve_cnt + SW'(1);
        end
    end

    // Response outputs; read data is gated to zero outside a valid beat.
    always_comb begin
        f_rvalid = 1'b0;
        f_rdata  = 32'd0;
        f_err    = 1'b0;
        l_rvalid = 1'b0;
        l_rdata  = 32'd0;
        l_err    = wr_err;

        case (state)
            F_RESP: begin
                if (!f_flush) begin
                    f_rvalid = 1'b1;
                    f_err    = resp_err;
                    f_rdata  = resp_err ? NOP : mem_rdata;
                end
            end
            L_RESP: begin
                l_rvalid = 1'b1;
                l_err    = resp_err;
                l_rdata  = resp_err ? 32'd0 : mem_rdata;
            end
            default: ;
        endcase
    end

endmodule
